// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART serializer through a start/busy handshake
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          WR_EN,
  input  logic [7:0]    WR_DATA,
  input  logic          CLR_OVF,
  input  logic          TX_BUSY,
  output logic          TX_START,
  output logic [7:0]    TX_DATA,
  output logic          FULL,
  output logic          EMPTY,
  output logic [AW:0]   COUNT,
  output logic          OVERFLOW
);
  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count_n;
  logic [1:0] tmo, tmo_n;
  state_t state, state_n;
  logic wr_ok, pop;
  always_comb begin
    wr_ok = WR_EN && !FULL;
    pop = 1'b0;
    state_n = state;
    tmo_n = tmo;
    case (state)
      IDLE: if (!EMPTY && !TX_BUSY) begin
        pop = 1'b1;
        state_n = WAIT_HI;
        tmo_n = 2'd0;
      end
      WAIT_HI: if (TX_BUSY) begin
        state_n = WAIT_LO;
        tmo_n = 2'd0;
      end else if (tmo == 2'd3) begin
        state_n = IDLE;
        tmo_n = 2'd0;
      end else tmo_n = tmo + 2'd1;
      WAIT_LO: state_n = TX_BUSY ? WAIT_LO : IDLE;
      default: state_n = IDLE;
    endcase
    count_n = COUNT + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, pop};
  end
  always_ff @(posedge CLK)
    if (RST_N && wr_ok) mem[wr_ptr] <= WR_DATA;
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      COUNT <= '0;
      EMPTY <= 1'b1;
      FULL <= 1'b0;
      OVERFLOW <= 1'b0;
      TX_START <= 1'b0;
      TX_DATA <= 8'h00;
      state <= IDLE;
      tmo <= 2'd0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        TX_DATA <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      TX_START <= pop;
      COUNT <= count_n;
      FULL <= count_n == FULL_CNT;
      EMPTY <= count_n == '0;
      OVERFLOW <= CLR_OVF ? 1'b0 : (OVERFLOW || (WR_EN && FULL));
      state <= state_n;
      tmo <= tmo_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenarios against hand-computed FIFO/feeder behaviour
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic WR_EN = 1'b0;
  logic CLR_OVF = 1'b0;
  logic [7:0] WR_DATA = 8'h00;
  logic man_busy = 1'b0;
  logic ser_en = 1'b0;
  logic ser_busy = 1'b0;
  logic TX_BUSY;
  logic TX_START, FULL, EMPTY, OVERFLOW;
  logic [7:0] TX_DATA;
  logic [AW:0] COUNT;
  int ser_cnt = 0;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] rec[$];
  int rec_cyc[$];

  assign TX_BUSY = ser_en ? ser_busy : man_busy;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .CLR_OVF(CLR_OVF),
    .TX_BUSY(TX_BUSY), .TX_START(TX_START), .TX_DATA(TX_DATA), .FULL(FULL),
    .EMPTY(EMPTY), .COUNT(COUNT), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // start monitor plus a serializer model that stays busy 20 cycles per byte
  always @(negedge CLK) begin
    cyc++;
    if (TX_START) begin
      rec.push_back(TX_DATA);
      rec_cyc.push_back(cyc);
    end
    if (ser_en && TX_START) ser_cnt = 20;
    else if (ser_cnt > 0) ser_cnt--;
    ser_busy = ser_cnt > 0;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push(input logic [7:0] d);
    WR_EN = 1'b1;
    WR_DATA = d;
    @(negedge CLK);
    WR_EN = 1'b0;
  endtask

  task automatic clear_rec();
    rec.delete();
    rec_cyc.delete();
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200 && !(EMPTY && !TX_BUSY); k++) @(negedge CLK);
    n_chk++;
    if (k >= 200) begin n_fail++; $display("FAIL idle_timeout got busy=%0b empty=%0b exp idle", TX_BUSY, EMPTY); end
    tick(3);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    tick(2);
    n_chk++; if (COUNT !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", COUNT); end
    n_chk++; if (EMPTY !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0b exp 1", EMPTY); end
    n_chk++; if (FULL !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b exp 0", FULL); end
    n_chk++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b exp 0", OVERFLOW); end
    n_chk++; if (TX_START !== 1'b0) begin n_fail++; $display("FAIL reset_start got %0b exp 0", TX_START); end
    n_chk++; if (TX_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", TX_DATA); end
    RST_N = 1'b1;
    tick(1);
  endtask

  task automatic test_single();
    clear_rec();
    push(8'hA5);
    n_chk++; if (COUNT !== 5'd1) begin n_fail++; $display("FAIL single_count_e0 got %0d exp 1", COUNT); end
    n_chk++; if (EMPTY !== 1'b0) begin n_fail++; $display("FAIL single_empty_e0 got %0b exp 0", EMPTY); end
    n_chk++; if (TX_START !== 1'b0) begin n_fail++; $display("FAIL single_start_e0 got %0b exp 0", TX_START); end
    tick(1);
    n_chk++; if (TX_START !== 1'b1) begin n_fail++; $display("FAIL single_start_e1 got %0b exp 1", TX_START); end
    n_chk++; if (TX_DATA !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h exp a5", TX_DATA); end
    n_chk++; if (EMPTY !== 1'b1) begin n_fail++; $display("FAIL single_empty_e1 got %0b exp 1", EMPTY); end
    tick(1);
    n_chk++; if (TX_START !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width got %0b exp 0", TX_START); end
    n_chk++; if (TX_DATA !== 8'hA5) begin n_fail++; $display("FAIL single_data_hold got %h exp a5", TX_DATA); end
    man_busy = 1'b1;
    tick(5);
    man_busy = 1'b0;
    tick(10);
    n_chk++; if (rec.size() !== 1) begin n_fail++; $display("FAIL single_start_count got %0d exp 1", rec.size()); end
  endtask

  task automatic test_burst();
    logic [AW:0] peak = '0;
    int gap;
    ser_en = 1'b1;
    clear_rec();
    for (int i = 1; i <= 16; i++) begin
      push(8'(i));
      if (COUNT > peak) peak = COUNT;
    end
    for (int k = 0; k < 600 && rec.size() < 16; k++) @(negedge CLK);
    n_chk++; if (rec.size() !== 16) begin n_fail++; $display("FAIL burst_starts got %0d exp 16", rec.size()); end
    for (int i = 0; i < rec.size() && i < 16; i++) begin
      n_chk++; if (rec[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL burst_order[%0d] got %h exp %h", i, rec[i], 8'(i + 1)); end
    end
    n_chk++; if (peak < 5'd15 || peak > 5'd16) begin n_fail++; $display("FAIL burst_peak got %0d exp 15..16", peak); end
    n_chk++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL burst_ovf got %0b exp 0", OVERFLOW); end
    gap = rec_cyc.size() >= 2 ? rec_cyc[1] - rec_cyc[0] : -1;
    n_chk++; if (gap !== 22) begin n_fail++; $display("FAIL burst_gap got %0d exp 22", gap); end
    wait_idle();
    ser_en = 1'b0;
  endtask

  task automatic test_overflow();
    man_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    n_chk++; if (FULL !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %0b exp 1", FULL); end
    n_chk++; if (COUNT !== 5'd16) begin n_fail++; $display("FAIL ovf_count16 got %0d exp 16", COUNT); end
    n_chk++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL ovf_pre got %0b exp 0", OVERFLOW); end
    push(8'hEE);
    n_chk++; if (OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %0b exp 1", OVERFLOW); end
    n_chk++; if (COUNT !== 5'd16) begin n_fail++; $display("FAIL ovf_count17 got %0d exp 16", COUNT); end
    CLR_OVF = 1'b1;
    WR_EN = 1'b1;
    WR_DATA = 8'hDD;
    tick(1);
    CLR_OVF = 1'b0;
    WR_EN = 1'b0;
    n_chk++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL ovf_clr_priority got %0b exp 0", OVERFLOW); end
    n_chk++; if (COUNT !== 5'd16) begin n_fail++; $display("FAIL ovf_count_clr got %0d exp 16", COUNT); end
    clear_rec();
    man_busy = 1'b0;
    WR_EN = 1'b1;
    WR_DATA = 8'hCC;
    tick(1);
    WR_EN = 1'b0;
    n_chk++; if (TX_START !== 1'b1 || TX_DATA !== 8'h20) begin n_fail++; $display("FAIL fullpop_start got %0b/%h exp 1/20", TX_START, TX_DATA); end
    n_chk++; if (COUNT !== 5'd15) begin n_fail++; $display("FAIL fullpop_count got %0d exp 15", COUNT); end
    n_chk++; if (OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL fullpop_ovf got %0b exp 1", OVERFLOW); end
    for (int k = 0; k < 200 && rec.size() < 16; k++) @(negedge CLK);
    n_chk++; if (rec.size() !== 16) begin n_fail++; $display("FAIL ovf_drain got %0d exp 16", rec.size()); end
    for (int i = 0; i < rec.size() && i < 16; i++) begin
      n_chk++; if (rec[i] !== 8'h20 + 8'(i)) begin n_fail++; $display("FAIL ovf_order[%0d] got %h exp %h", i, rec[i], 8'h20 + 8'(i)); end
    end
    CLR_OVF = 1'b1;
    tick(1);
    CLR_OVF = 1'b0;
    wait_idle();
  endtask

  task automatic test_simultaneous();
    man_busy = 1'b1;
    push(8'h31);
    push(8'h32);
    push(8'h33);
    n_chk++; if (COUNT !== 5'd3) begin n_fail++; $display("FAIL simul_pre got %0d exp 3", COUNT); end
    clear_rec();
    man_busy = 1'b0;
    WR_EN = 1'b1;
    WR_DATA = 8'h34;
    tick(1);
    WR_EN = 1'b0;
    man_busy = 1'b1;
    n_chk++; if (COUNT !== 5'd3) begin n_fail++; $display("FAIL simul_count got %0d exp 3", COUNT); end
    n_chk++; if (TX_START !== 1'b1 || TX_DATA !== 8'h31) begin n_fail++; $display("FAIL simul_start got %0b/%h exp 1/31", TX_START, TX_DATA); end
    tick(2);
    n_chk++; if (COUNT !== 5'd3 || rec.size() !== 1) begin n_fail++; $display("FAIL simul_hold got %0d/%0d exp 3/1", COUNT, rec.size()); end
    man_busy = 1'b0;
    ser_en = 1'b1;
    for (int k = 0; k < 200 && rec.size() < 4; k++) @(negedge CLK);
    n_chk++; if (rec.size() !== 4) begin n_fail++; $display("FAIL simul_drain got %0d exp 4", rec.size()); end
    for (int i = 0; i < rec.size() && i < 4; i++) begin
      n_chk++; if (rec[i] !== 8'h31 + 8'(i)) begin n_fail++; $display("FAIL simul_order[%0d] got %h exp %h", i, rec[i], 8'h31 + 8'(i)); end
    end
    wait_idle();
    ser_en = 1'b0;
  endtask

  task automatic test_wrap();
    ser_en = 1'b1;
    clear_rec();
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 100 && FULL; k++) @(negedge CLK);
      push(8'h40 + 8'(i));
    end
    for (int k = 0; k < 1200 && rec.size() < 40; k++) @(negedge CLK);
    n_chk++; if (rec.size() !== 40) begin n_fail++; $display("FAIL wrap_count got %0d exp 40", rec.size()); end
    for (int i = 0; i < rec.size() && i < 40; i++) begin
      n_chk++; if (rec[i] !== 8'h40 + 8'(i)) begin n_fail++; $display("FAIL wrap_order[%0d] got %h exp %h", i, rec[i], 8'h40 + 8'(i)); end
    end
    n_chk++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf got %0b exp 0", OVERFLOW); end
    wait_idle();
    ser_en = 1'b0;
  endtask

  task automatic test_timeout();
    int gap;
    man_busy = 1'b0;
    clear_rec();
    push(8'h51);
    push(8'h52);
    for (int k = 0; k < 40 && rec.size() < 2; k++) @(negedge CLK);
    n_chk++; if (rec.size() !== 2) begin n_fail++; $display("FAIL tmo_starts got %0d exp 2", rec.size()); end
    n_chk++; if (rec.size() >= 2 && (rec[0] !== 8'h51 || rec[1] !== 8'h52)) begin n_fail++; $display("FAIL tmo_data got %h %h exp 51 52", rec[0], rec[1]); end
    gap = rec_cyc.size() >= 2 ? rec_cyc[1] - rec_cyc[0] : -1;
    n_chk++; if (gap !== 5) begin n_fail++; $display("FAIL tmo_gap got %0d exp 5", gap); end
    tick(8);
  endtask

  task automatic test_reset_mid();
    man_busy = 1'b1;
    for (int i = 0; i < 5; i++) push(8'h61 + 8'(i));
    n_chk++; if (COUNT !== 5'd5) begin n_fail++; $display("FAIL rst_pre got %0d exp 5", COUNT); end
    RST_N = 1'b0;
    WR_EN = 1'b1;
    WR_DATA = 8'h77;
    tick(1);
    RST_N = 1'b1;
    WR_EN = 1'b0;
    n_chk++; if (COUNT !== 5'd0 || EMPTY !== 1'b1 || FULL !== 1'b0) begin n_fail++; $display("FAIL rst_mid got count=%0d empty=%0b full=%0b exp 0/1/0", COUNT, EMPTY, FULL); end
    clear_rec();
    man_busy = 1'b0;
    tick(12);
    n_chk++; if (rec.size() !== 0 || EMPTY !== 1'b1) begin n_fail++; $display("FAIL rst_no_start got starts=%0d empty=%0b exp 0/1", rec.size(), EMPTY); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_simultaneous();
    test_wrap();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
